// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward receive frame FIFO behind the 10G MAC RX stream.
// Good frames are committed on tlast. Errored or overflowing frames are rolled back to the last commit.
module eth_rx_frame_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int ADDR_WIDTH = 9,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk156,
   input  logic                  sys_rst,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic [CNT_WIDTH-1:0]  good_frames,
   output logic [CNT_WIDTH-1:0]  err_drops,
   output logic [CNT_WIDTH-1:0]  ovf_drops,
   output logic [ADDR_WIDTH:0]   fifo_level
);

   localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam int DEPTH   = 2**ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WRITE   = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [ENTRY_W-1:0]   r_mem [DEPTH];
   logic [ADDR_WIDTH:0]  r_wr_ptr;
   logic [ADDR_WIDTH:0]  r_commit_ptr;
   logic [ADDR_WIDTH:0]  r_rd_ptr;
   logic [1:0]           r_state;
   logic [ENTRY_W-1:0]   r_rd_data;
   logic                 r_s1_valid;
   logic                 r_out_valid;
   logic [ENTRY_W-1:0]   r_out_entry;
   logic [CNT_WIDTH-1:0] r_good;
   logic [CNT_WIDTH-1:0] r_err;
   logic [CNT_WIDTH-1:0] r_ovf;
   logic [ADDR_WIDTH:0]  r_level;

   logic [ADDR_WIDTH:0]  w_used;
   logic                 w_full;
   logic                 w_wr_en;
   logic                 w_out_ready;
   logic                 w_rd_en;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Occupancy never exceeds DEPTH, so its top bit is exactly the full flag.
   assign w_used  = r_wr_ptr - r_rd_ptr;
   assign w_full  = w_used[ADDR_WIDTH];
   assign w_wr_en = s_axis_tvalid && (r_state != ST_DISCARD) && !w_full;

   assign w_out_ready = !r_out_valid || m_axis_tready;
   assign w_rd_en     = (r_rd_ptr != r_commit_ptr) && (!r_s1_valid || w_out_ready);

   // NOTE: the buffer RAM is not reset so it maps onto block RAM; the pointers alone say what is valid.
   always_ff @(posedge clk156) begin
      if (w_wr_en)
         r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      if (w_rd_en)
         r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk156 or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_state      <= ST_IDLE;
         r_good       <= '0;
         r_err        <= '0;
         r_ovf        <= '0;
      end else if (s_axis_tvalid) begin
         case (r_state)
            ST_IDLE, ST_WRITE: begin
               if (!w_full) begin
                  if (s_axis_tlast && s_axis_tuser) begin
                     r_wr_ptr <= r_commit_ptr;
                     r_err    <= sat_inc(r_err);
                     r_state  <= ST_IDLE;
                  end else if (s_axis_tlast) begin
                     r_wr_ptr     <= r_wr_ptr + 1'b1;
                     r_commit_ptr <= r_wr_ptr + 1'b1;
                     r_good       <= sat_inc(r_good);
                     r_state      <= ST_IDLE;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                     r_state  <= ST_WRITE;
                  end
               end else begin
                  r_wr_ptr <= r_commit_ptr;
                  if (s_axis_tlast) begin
                     r_ovf   <= sat_inc(r_ovf);
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_DISCARD;
                  end
               end
            end
            ST_DISCARD: begin
               if (s_axis_tlast) begin
                  r_ovf   <= sat_inc(r_ovf);
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Prefetch stage plus output register: the RAM is read ahead so the output behaves as FWFT.
   always_ff @(posedge clk156 or posedge sys_rst) begin
      if (sys_rst) begin
         r_rd_ptr    <= '0;
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_entry <= '0;
         r_level     <= '0;
      end else begin
         r_level <= w_used;
         if (w_rd_en) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_s1_valid <= 1'b1;
         end else if (w_out_ready) begin
            r_s1_valid <= 1'b0;
         end
         if (w_out_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
               r_out_entry <= r_rd_data;
         end
      end
   end

   assign m_axis_tvalid = r_out_valid;
   assign m_axis_tdata  = r_out_entry[DATA_WIDTH-1:0];
   assign m_axis_tkeep  = r_out_entry[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis_tlast  = r_out_entry[ENTRY_W-1];
   assign good_frames   = r_good;
   assign err_drops     = r_err;
   assign ovf_drops     = r_ovf;
   assign fifo_level    = r_level;

endmodule
